// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I sequencer: owns cpu_state, the EXEC stage counter and the instruction
// register, assembles fetches from a narrow bus and runs load/store beats and traps.
module instr_sequencer #(
  parameter int unsigned BUS_BYTES = 1,
  parameter int unsigned STG_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  input  logic                   mem_ack_i,
  input  logic [8*BUS_BYTES-1:0] mem_rdata_i,
  output logic [1:0]             mem_beat_o,
  input  logic [1:0]             addr_lsb_i,
  input  logic [2:0]             alu_flags_i,
  output logic [3:0]             cpu_state_o,
  output logic [STG_W-1:0]       instr_stg_o,
  output logic [31:0]            instr_o,
  output logic                   br_taken_o,
  output logic                   retire_o,
  output logic                   trap_o,
  output logic [1:0]             trap_cause_o
);

  if (BUS_BYTES != 1 && BUS_BYTES != 2 && BUS_BYTES != 4) begin : g_bad_bus
    $error("instr_sequencer: BUS_BYTES must be 1, 2 or 4");
  end

  localparam int unsigned BeatW     = 8 * BUS_BYTES;
  localparam logic [1:0]  FetchLast = 2'(4 / BUS_BYTES - 1);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    StFetch = 4'd0,
    StIdle  = 4'd1,
    StExec  = 4'd2,
    StMem   = 4'd3,
    StTrap  = 4'd15
  } state_e;

  state_e           state_q;
  logic [STG_W-1:0] stg_q;
  logic [1:0]       beat_q;
  logic [31:0]      instr_q;
  logic [2:0]       flags_q;
  logic [1:0]       cause_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, signed_load;
  logic        addr_stage, misaligned, last_stg, retire, br_taken;
  logic [2:0]  size_b;
  logic [1:0]  mem_last;
  logic [31:0] fetch_word;

  function automatic logic is_legal(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpReg: is_legal = 1'b1;
      OpBranch: is_legal = (f3 != 3'b010) && (f3 != 3'b011);
      OpLoad:   is_legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      OpStore:  is_legal = (f3 <= 3'b010);
      default:  is_legal = 1'b0;
    endcase
  endfunction

  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign is_load     = (opcode == OpLoad);
  assign is_store    = (opcode == OpStore);
  assign is_branch   = (opcode == OpBranch);
  assign signed_load = is_load && (funct3[2:1] == 2'b00);
  assign addr_stage  = (is_load && stg_q == '0) || (is_store && stg_q == STG_W'(1));
  assign misaligned  = (funct3[1:0] == 2'b01 && addr_lsb_i[0]) ||
                       (funct3[1:0] == 2'b10 && addr_lsb_i != 2'b00);

  // Word as it will look once the current beat lands; legality is judged on this.
  always_comb begin
    fetch_word = instr_q;
    fetch_word[32'(beat_q) * BeatW +: BeatW] = mem_rdata_i;
  end

  always_comb begin
    size_b = 3'd4;
    case (funct3[1:0])
      2'b00:   size_b = 3'd1;
      2'b01:   size_b = 3'd2;
      default: size_b = 3'd4;
    endcase
    mem_last = 2'd0;
    if (32'(size_b) > BUS_BYTES) mem_last = 2'(32'(size_b) / BUS_BYTES - 32'd1);
  end

  always_comb begin
    last_stg = 1'b0;
    case (opcode)
      OpBranch:        last_stg = (stg_q == STG_W'(1));
      OpJalr, OpStore: last_stg = (stg_q == STG_W'(2));
      OpLoad:          last_stg = signed_load ? (stg_q == STG_W'(2)) : (stg_q == STG_W'(1));
      default:         last_stg = (stg_q == '0);
    endcase
  end

  assign retire = (state_q == StExec) && last_stg;

  always_comb begin
    br_taken = 1'b0;
    if (state_q == StExec && is_branch && stg_q == STG_W'(1)) begin
      case (funct3)
        3'b000:  br_taken = flags_q[0];
        3'b001:  br_taken = !flags_q[0];
        3'b100:  br_taken = flags_q[1];
        3'b101:  br_taken = !flags_q[1];
        3'b110:  br_taken = flags_q[2];
        3'b111:  br_taken = !flags_q[2];
        default: br_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stg_q   <= '0;
      beat_q  <= '0;
      instr_q <= '0;
      flags_q <= '0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (mem_ack_i) begin
            instr_q <= fetch_word;
            if (beat_q == FetchLast) begin
              beat_q <= '0;
              stg_q  <= '0;
              if (is_legal(fetch_word)) begin
                state_q <= StExec;
              end else begin
                state_q <= StTrap;
                cause_q <= 2'd1;
              end
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        StExec: begin
          if (retire) begin
            state_q <= StFetch;
            stg_q   <= '0;
            beat_q  <= '0;
          end else if (addr_stage && misaligned) begin
            state_q <= StTrap;
            cause_q <= is_store ? 2'd3 : 2'd2;
          end else if (addr_stage) begin
            state_q <= StMem;
            beat_q  <= '0;
          end else begin
            // Only branch stage 0 reaches here for a branch.
            if (is_branch) flags_q <= alu_flags_i;
            stg_q <= stg_q + STG_W'(1);
          end
        end
        StMem: begin
          if (mem_ack_i) begin
            if (beat_q == mem_last) begin
              state_q <= StExec;
              stg_q   <= stg_q + STG_W'(1);
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        StTrap:  state_q <= StTrap;
        default: state_q <= StTrap;
      endcase
    end
  end

  assign cpu_state_o  = state_q;
  assign instr_stg_o  = stg_q;
  assign instr_o      = instr_q;
  assign mem_beat_o   = beat_q;
  assign mem_req_o    = (state_q == StFetch) || (state_q == StMem);
  assign mem_we_o     = (state_q == StMem) && is_store;
  assign retire_o     = retire;
  assign br_taken_o   = br_taken;
  assign trap_o       = (state_q == StTrap);
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a per-instruction schedule model predicts every
// output each cycle for a BUS_BYTES=1 instance and a BUS_BYTES=2 instance.
module tb_instr_sequencer;

  localparam int SFetch = 0, SIdle = 1, SExec = 2, SMem = 3, STrap = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, rst_n2, mem_ack, ack1, ack2;
  logic [15:0] rdata;
  logic [1:0]  addr_lsb;
  logic [2:0]  alu_flags;
  bit          sel;

  logic        req1, we1, brt1, ret1, trp1, req2, we2, brt2, ret2, trp2;
  logic [1:0]  beat1, cau1, beat2, cau2;
  logic [3:0]  st1, st2;
  logic [2:0]  stg1, stg2;
  logic [31:0] ins1, ins2;

  assign ack1 = mem_ack & ~sel;
  assign ack2 = mem_ack & sel;

  instr_sequencer #(.BUS_BYTES(1), .STG_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .mem_req_o(req1), .mem_we_o(we1), .mem_ack_i(ack1),
    .mem_rdata_i(rdata[7:0]), .mem_beat_o(beat1), .addr_lsb_i(addr_lsb),
    .alu_flags_i(alu_flags), .cpu_state_o(st1), .instr_stg_o(stg1), .instr_o(ins1),
    .br_taken_o(brt1), .retire_o(ret1), .trap_o(trp1), .trap_cause_o(cau1)
  );

  instr_sequencer #(.BUS_BYTES(2), .STG_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .mem_req_o(req2), .mem_we_o(we2), .mem_ack_i(ack2),
    .mem_rdata_i(rdata), .mem_beat_o(beat2), .addr_lsb_i(addr_lsb),
    .alu_flags_i(alu_flags), .cpu_state_o(st2), .instr_stg_o(stg2), .instr_o(ins2),
    .br_taken_o(brt2), .retire_o(ret2), .trap_o(trp2), .trap_cause_o(cau2)
  );

  logic        a_req, a_we, a_brt, a_ret, a_trp;
  logic [1:0]  a_beat, a_cau;
  logic [3:0]  a_st;
  logic [2:0]  a_stg;
  logic [31:0] a_ins;
  assign a_req  = sel ? req2  : req1;
  assign a_we   = sel ? we2   : we1;
  assign a_brt  = sel ? brt2  : brt1;
  assign a_ret  = sel ? ret2  : ret1;
  assign a_trp  = sel ? trp2  : trp1;
  assign a_beat = sel ? beat2 : beat1;
  assign a_cau  = sel ? cau2  : cau1;
  assign a_st   = sel ? st2   : st1;
  assign a_stg  = sel ? stg2  : stg1;
  assign a_ins  = sel ? ins2  : ins1;

  logic [31:0] e_st, e_stg, e_req, e_we, e_beat, e_brt, e_ret, e_trp, e_cau, e_ins;
  bit          chk;
  int          checks, errors, cycno, first_ret, we_cycles;
  logic        last_ret_brt;

  int          bb;
  logic [31:0] m_instr;
  int          m_cause;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      cmp("cpu_state", 32'(a_st), e_st);
      cmp("instr_stg", 32'(a_stg), e_stg);
      cmp("mem_req", 32'(a_req), e_req);
      cmp("mem_we", 32'(a_we), e_we);
      cmp("mem_beat", 32'(a_beat), e_beat);
      cmp("br_taken", 32'(a_brt), e_brt);
      cmp("retire", 32'(a_ret), e_ret);
      cmp("trap", 32'(a_trp), e_trp);
      cmp("trap_cause", 32'(a_cau), e_cau);
      cmp("instr", a_ins, e_ins);
      if (a_ret === 1'b1) begin
        last_ret_brt = a_brt;
        if (!sel && first_ret < 0) first_ret = cycno;
      end
      if (a_we === 1'b1) we_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycno++;
  endtask

  task automatic ex(input int st, input int stg, input int req, input int we, input int beat,
                    input int brt, input int ret, input int trp);
    e_st = st; e_stg = stg; e_req = req; e_we = we; e_beat = beat;
    e_brt = brt; e_ret = ret; e_trp = trp; e_cau = m_cause; e_ins = m_instr;
  endtask

  function automatic bit m_legal(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33: return 1'b1;
      7'h63:   return !(f3 == 3'd2 || f3 == 3'd3);
      7'h03:   return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      7'h23:   return f3 <= 3'd2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_taken(input logic [2:0] f3, input logic [2:0] fl);
    case (f3)
      3'd0:    return int'(fl[0]);
      3'd1:    return int'(!fl[0]);
      3'd4:    return int'(fl[1]);
      3'd5:    return int'(!fl[1]);
      3'd6:    return int'(fl[2]);
      3'd7:    return int'(!fl[2]);
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    if (sel) rst_n2 = 1'b0;
    else rst_n1 = 1'b0;
    m_instr = '0;
    m_cause = 0;
    ex(SIdle, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ex(SIdle, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if (sel) rst_n2 = 1'b1;
    else rst_n1 = 1'b1;
    cycno = 1;
    ex(SIdle, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic fetch(input logic [31:0] w, input int wt);
    for (int k = 0; k < 4 / bb; k++) begin
      for (int i = 0; i <= wt; i++) begin
        mem_ack = (i == wt);
        rdata   = 16'(w >> (8 * bb * k));
        ex(SFetch, 0, 1, 0, k, 0, 0, 0);
        tick();
        if (i == wt)
          for (int j = bb * k; j < bb * k + bb; j++) m_instr[8*j +: 8] = w[8*j +: 8];
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic mem(input int nb, input int we, input int stg, input int wt);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i <= wt; i++) begin
        mem_ack = (i == wt);
        rdata   = 16'($urandom);
        ex(SMem, stg, 1, we, b, 0, 0, 0);
        tick();
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic trap_hold(input int cause, input int n, input int stg);
    m_cause = cause;
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'b1;
      rdata     = 16'($urandom);
      alu_flags = 3'($urandom);
      ex(STrap, stg, 0, 0, 0, 0, 0, 1);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic run(input logic [31:0] w, input int fwt, input logic [2:0] fl,
                     input logic [1:0] lsb, input int mwt);
    logic [2:0] f3;
    int size, nb;
    bit mis, sgn;
    f3   = w[14:12];
    fetch(w, fwt);
    if (!m_legal(w)) begin
      trap_hold(1, 20, 0);
      return;
    end
    size = 1 << f3[1:0];
    nb   = (size > bb) ? size / bb : 1;
    mis  = (size == 2 && lsb[0]) || (size == 4 && lsb != 2'b00);
    sgn  = (f3 == 3'd0 || f3 == 3'd1);
    case (w[6:0])
      7'h63: begin
        alu_flags = fl;
        ex(SExec, 0, 0, 0, 0, 0, 0, 0); tick();
        alu_flags = ~fl;
        ex(SExec, 1, 0, 0, 0, m_taken(f3, fl), 1, 0); tick();
      end
      7'h67: begin
        for (int s = 0; s < 3; s++) begin
          ex(SExec, s, 0, 0, 0, 0, int'(s == 2), 0); tick();
        end
      end
      7'h03: begin
        addr_lsb = lsb;
        ex(SExec, 0, 0, 0, 0, 0, 0, 0); tick();
        addr_lsb = ~lsb;
        if (mis) begin
          trap_hold(2, 5, 0);
          return;
        end
        mem(nb, 0, 0, mwt);
        ex(SExec, 1, 0, 0, 0, 0, int'(!sgn), 0); tick();
        if (sgn) begin
          ex(SExec, 2, 0, 0, 0, 0, 1, 0); tick();
        end
      end
      7'h23: begin
        addr_lsb = ~lsb;
        ex(SExec, 0, 0, 0, 0, 0, 0, 0); tick();
        addr_lsb = lsb;
        ex(SExec, 1, 0, 0, 0, 0, 0, 0); tick();
        addr_lsb = ~lsb;
        if (mis) begin
          trap_hold(3, 20, 1);
          return;
        end
        mem(nb, 1, 1, mwt);
        ex(SExec, 2, 0, 0, 0, 0, 1, 0); tick();
      end
      default: begin
        ex(SExec, 0, 0, 0, 0, 0, 1, 0); tick();
      end
    endcase
  endtask

  initial begin
    int snap;
    rst_n1 = 1'b0; rst_n2 = 1'b0; mem_ack = 1'b0; rdata = '0;
    addr_lsb = '0; alu_flags = '0; sel = 1'b0; bb = 1;
    m_instr = '0; m_cause = 0; chk = 1'b0; checks = 0; errors = 0;
    cycno = 0; first_ret = -1; we_cycles = 0; last_ret_brt = 1'b0;
    @(posedge clk);
    #1;
    chk = 1'b1;

    do_reset();
    run(32'h00500093, 0, 3'b000, 2'd0, 0);
    cmp("addi_instr_lit", a_ins, 32'h00500093);
    cmp("cycle7_fetch_lit", 32'(a_st), 32'(SFetch));
    cmp("first_retire_cycle_lit", 32'(first_ret), 32'd6);

    run(32'h00208463, 0, 3'b001, 2'd0, 0);
    cmp("beq_taken_lit", 32'(last_ret_brt), 32'd1);
    run(32'h00208463, 0, 3'b000, 2'd0, 0);
    cmp("beq_not_taken_lit", 32'(last_ret_brt), 32'd0);
    run(32'h0020F463, 0, 3'b100, 2'd0, 0);
    cmp("bgeu_not_taken_lit", 32'(last_ret_brt), 32'd0);

    run(32'h0000A103, 1, 3'b000, 2'd0, 2);
    run(32'h000080E7, 0, 3'b000, 2'd0, 0);
    run(32'h0000C103, 0, 3'b000, 2'd3, 0);
    run(32'h00009103, 0, 3'b000, 2'd2, 1);
    run(32'h0020A023, 0, 3'b000, 2'd0, 1);

    snap = we_cycles;
    run(32'h0020A023, 0, 3'b000, 2'd2, 0);
    cmp("sw_mis_cause_lit", 32'(a_cau), 32'd3);
    cmp("sw_mis_no_we_beats", 32'(we_cycles - snap), 32'd0);

    do_reset();
    fetch(32'h0000A103, 0);
    addr_lsb = 2'd0;
    ex(SExec, 0, 0, 0, 0, 0, 0, 0); tick();
    mem_ack = 1'b0;
    ex(SMem, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n1 = 1'b0;
    #1;
    cmp("rst_mid_req_lit", 32'(a_req), 32'd0);
    cmp("rst_mid_state_lit", 32'(a_st), 32'(SIdle));
    cmp("rst_mid_instr_lit", a_ins, 32'd0);
    m_instr = '0;
    ex(SIdle, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n1 = 1'b1;
    cycno = 1;
    ex(SIdle, 0, 0, 0, 0, 0, 0, 0);
    tick();
    run(32'h00500093, 0, 3'b000, 2'd0, 0);

    run(32'h0000007F, 0, 3'b000, 2'd0, 0);
    cmp("illegal_cause_lit", 32'(a_cau), 32'd1);
    do_reset();
    run(32'h0000000F, 1, 3'b000, 2'd0, 0);

    sel = 1'b1;
    rst_n1 = 1'b0;
    bb = 2;
    do_reset();
    run(32'h00008103, 0, 3'b000, 2'd1, 0);
    run(32'h00009103, 1, 3'b000, 2'd0, 1);
    run(32'h0000A103, 0, 3'b000, 2'd0, 0);
    run(32'h00500093, 0, 3'b000, 2'd0, 0);

    chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised multi-cycle sequencer for the RV32I core. It owns `cpu_state`, the `instr_stg` stage counter and the instruction register, and assembles instructions from a memory bus `BUS_BYTES` wide. It also performs the byte-beat handshake for loads and stores, captures ALU flags for branches, and traps on illegal or misaligned instructions. Its `cpu_state`, `instr_stg` and `instr` outputs drive the combinational datapath control decoder.

## Interface
- `BUS_BYTES`, 1: memory beat width in bytes.
  - Legal values are 1, 2 and 4.
  - Any other value is an elaboration error.
- `STG_W`, 3: width of `instr_stg`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  bus request; held until `mem_ack`.
- `mem_we`  out  1  write beat (store); valid with `mem_req`.
- `mem_ack`  in  1  beat accepted at this edge; ignored when `mem_req`=0.
- `mem_rdata`  in  8*BUS_BYTES  read beat data.
- `mem_beat`  out  2  beat index within the current access.
- `addr_lsb`  in  2  effective address [1:0], sampled in the address stage.
- `alu_flags`  in  3  {ltu, lt, zero} of rs1-rs2.
- `cpu_state`  out  4  1 IDLE, 0 FETCH, 2 EXEC, 3 MEM, 15 TRAP.
- `instr_stg`  out  STG_W  EXEC stage index.
- `instr`  out  32  current instruction.
- `br_taken`  out  1  branch decision; valid in branch stage 1 only.
- `retire`  out  1  one-cycle pulse; the instruction's last cycle, PC write enable.
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  0 none, 1 illegal, 2 misaligned load, 3 misaligned store.

## Operation
- **Reset values:**
  - `cpu_state`=IDLE and `instr`=0.
  - `instr_stg`, `mem_beat`, captured flags and `trap_cause` are 0.
  - All 1-bit outputs are 0.
- **IDLE:** moves to FETCH unconditionally on the next edge.
- **FETCH:**
  - `mem_req`=1, `mem_we`=0.
  - Beat k is written to `instr[8*BUS_BYTES*k +: 8*BUS_BYTES]` (little-endian).
  - A fetch takes 4/BUS_BYTES beats; `mem_beat` increments on each ack.
  - On the ack of the last beat, legality is checked on the assembled word.
  - If legal, go to EXEC with `instr_stg`=0; otherwise go to TRAP with cause 1.
- **Illegal instructions:**
  - Opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3 above 010.
  - FENCE and SYSTEM are illegal in this generation.
- **Stage schedules in EXEC** (`instr_stg` increments by 1 per cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL: stage 0 only; `retire` in stage 0.
  - JALR: stages 0, 1, 2; `retire` in stage 2.
  - BRANCH:
    - Stage 0 captures `alu_flags`.
    - Stage 1 drives `br_taken` and `retire`.
    - `br_taken` by funct3: beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu.
  - LOAD:
    - Stage 0 is the address stage and checks alignment.
    - Then MEM for max(1, size/BUS_BYTES) beats, where size is 1, 2 or 4 bytes.
    - Then EXEC stage 1 (write-back).
    - Signed lb/lh also run stage 2 (sign extension) and retire there; all other loads retire in stage 1.
  - STORE:
    - Stage 0 captures rs2.
    - Stage 1 is the address stage and checks alignment.
    - Then MEM with `mem_we`=1.
    - Then EXEC stage 2, which retires.
- **Misalignment:**
  - Half-word access with `addr_lsb[0]`=1, or word access with `addr_lsb`≠0, is misaligned.
  - Misaligned loads and stores go to TRAP with cause 2 (load) or 3 (store) at the address-stage edge.
  - No MEM request is issued.
- **MEM:**
  - `mem_req`=1 and `mem_beat` counts from 0.
  - `instr_stg` holds its value while waiting for `mem_ack`.
  - The last ack returns to EXEC with `instr_stg`+1.
- **After retire:** next state is FETCH; `instr_stg` and `mem_beat` clear to 0.
- **TRAP:**
  - `trap`=1; `mem_req`, `retire` and `br_taken` are 0.
  - TRAP is left only by reset.

## Timing
- `mem_req`, `mem_we` and `mem_beat` are decoded from registered state only, with no combinational path from `mem_ack`.
- A beat completes at the rising edge where `mem_req` and `mem_ack` are both 1.
- Wait states (`mem_ack`=0) stretch FETCH/MEM indefinitely; no other state changes.
- A zero-wait fetch lasts 4/BUS_BYTES cycles.
- With `BUS_BYTES`=1, the first `retire` of a single-stage instruction occurs in cycle 6 after reset release: 1 IDLE, 4 FETCH, then EXEC.
- `br_taken` is combinational from the captured flags and `instr[14:12]`; it is 0 outside branch stage 1.
- `retire` is high for exactly one cycle per instruction.
- Asserting `rst_n` low mid-access clears all state asynchronously, and `mem_req` drops in the same cycle. A partially assembled `instr` is discarded.

## Test plan
- **Single-stage instruction:** `BUS_BYTES`=1, zero-wait, fetch of 0x00500093 (addi) -> `mem_beat` 0..3, `instr`=0x00500093, EXEC stage 0 with `retire`=1 in cycle 6, FETCH in cycle 7.
- **Branch taken:** beq 0x00208463 with `alu_flags`=3'b001 in stage 0 -> stage 1 has `br_taken`=1 and `retire`=1.
- **Branch not taken:** repeat with `alu_flags`=3'b000 -> `br_taken`=0 and `retire`=1.
- **Word load with wait states:** `BUS_BYTES`=1, lw with `addr_lsb`=0, `mem_ack` delayed 2 cycles per beat -> 4 MEM beats, `instr_stg` held at 0, then retire in stage 1.
- **Signed byte load:** `BUS_BYTES`=2, lb -> 1 MEM beat, retire in stage 2.
- **Misaligned store:** sw with `addr_lsb`=2 -> TRAP, `trap_cause`=3, no `mem_we` beat.
- **Illegal instruction:** fetch of 0x0000007F -> TRAP with `trap_cause`=1; outputs stay frozen for 20 cycles.
- **Reset mid-operation:** `rst_n` pulsed low during a MEM beat -> `mem_req`=0 immediately, IDLE and then FETCH.
